// File: rtl/buffer_arbiter_pkg.sv
// Shared constants and helpers for the buffer arbiter: requester bounds,
// index width derivation and index-to-one-hot conversion.
package buffer_arbiter_pkg;

  localparam int unsigned MIN_REQ = 2;
  localparam int unsigned MAX_REQ = 16;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  function automatic bit num_req_ok(input int unsigned n, input int unsigned src_w);
    return (n >= MIN_REQ) && (n <= MAX_REQ) && (src_w == clog2(n));
  endfunction

  function automatic logic [MAX_REQ-1:0] to_onehot(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/buffer_arbiter_rr_grant.sv
// Combinational round-robin pick: first requester at or after ptr (mod NUM_REQ),
// one-hot grant gated by en, binary index always reported for the data mux.
module rr_grant
  import buffer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned SRC_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [SRC_WIDTH-1:0] ptr,
  input  logic                 en,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SRC_WIDTH-1:0] idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned pos;
      pos = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[pos[SRC_WIDTH-1:0]]) begin
        found = 1'b1;
        idx   = pos[SRC_WIDTH-1:0];
      end
    end
    if (found && en) grant = NUM_REQ'(to_onehot(32'(idx)));
  end

endmodule

// File: rtl/negative_register.sv
// Negedge register with synchronous active-high reset and load enable.
module negative_register #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(negedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/register.sv
// Posedge register with synchronous active-high reset and load enable.
module register #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/buffer_arbiter.sv
// Round-robin arbiter feeding one shared single-entry buffer: posedge capture
// stage followed by a negedge re-time stage presenting data and source index.
module buffer_arbiter
  import buffer_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned SRC_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_WIDTH-1:0]          out_src,
  input  logic                          out_ready
);

  if (!num_req_ok(NUM_REQ, SRC_WIDTH)) begin : g_bad_params
    $error("buffer_arbiter: NUM_REQ must be 2..16 and SRC_WIDTH must equal clog2(NUM_REQ)");
  end

  logic [SRC_WIDTH-1:0]  ptr;
  logic [SRC_WIDTH-1:0]  idx;
  logic [SRC_WIDTH-1:0]  s1_src;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [DATA_WIDTH-1:0] word;
  logic                  s1_valid;
  logic                  space;
  logic                  consume;
  logic                  transfer;

  assign consume  = out_valid & out_ready;
  assign space    = ~s1_valid | consume;
  assign transfer = |grant;
  assign word     = req_data[idx*DATA_WIDTH +: DATA_WIDTH];

  rr_grant #(
    .NUM_REQ  (NUM_REQ),
    .SRC_WIDTH(SRC_WIDTH)
  ) u_rr_grant (
    .req  (req),
    .ptr  (ptr),
    .en   (space & ~rst),
    .grant(grant),
    .idx  (idx)
  );

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (transfer)
      ptr <= (idx == SRC_WIDTH'(NUM_REQ-1)) ? '0 : idx + 1'b1;
  end

  // A consume without a new transfer only drops valid; data and source hold.
  register #(
    .WIDTH(1 + DATA_WIDTH + SRC_WIDTH)
  ) u_stage1 (
    .clk(clk),
    .rst(rst),
    .en (transfer | consume),
    .d  ({transfer, (transfer ? word : s1_data), (transfer ? idx : s1_src)}),
    .q  ({s1_valid, s1_data, s1_src})
  );

  negative_register #(
    .WIDTH(1 + DATA_WIDTH + SRC_WIDTH)
  ) u_stage2 (
    .clk(clk),
    .rst(rst),
    .en (1'b1),
    .d  ({s1_valid, s1_data, s1_src}),
    .q  ({out_valid, out_data, out_src})
  );

endmodule

// File: tb/tb_buffer_arbiter.sv
// Scoreboard bench for buffer_arbiter: transferred words are queued when a
// grant is expected and compared when the consumer takes them.
module tb_buffer_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  logic [SW+DW-1:0] sb[$];
  int unsigned      mptr;
  logic [NR-1:0]    last_grant;
  logic             samp_valid;
  logic [DW-1:0]    samp_data;
  logic [SW-1:0]    samp_src;
  int unsigned      waitc[NR];

  always #5 clk = ~clk;

  buffer_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .SRC_WIDTH (SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .out_ready(out_ready)
  );

  function automatic logic [NR*DW-1:0] words(input logic [DW-1:0] base);
    logic [NR*DW-1:0] w;
    for (int unsigned i = 0; i < NR; i++) w[i*DW +: DW] = base + DW'(i);
    return w;
  endfunction

  // One clock: sample after the negedge, check against the model, advance it.
  task automatic step();
    logic [NR-1:0] eg;
    logic [SW-1:0] gi;
    bit            found;
    @(negedge clk); #1;
    eg = '0; gi = '0; found = 1'b0;
    if (!rst && (sb.size() == 0 || out_ready)) begin
      for (int unsigned k = 0; k < NR; k++) begin
        int unsigned p;
        p = (mptr + k) % NR;
        if (!found && req[p]) begin
          found = 1'b1;
          gi    = SW'(p);
          eg[p] = 1'b1;
        end
      end
    end
    last_grant = grant;
    samp_valid = out_valid;
    samp_data  = out_data;
    samp_src   = out_src;
    vectors++;
    if (grant !== eg) begin
      miscompares++;
      $display("FAIL grant: got %b want %b (req %b)", grant, eg, req);
    end
    vectors++;
    if ($countones(grant) > 1) begin
      miscompares++;
      $display("FAIL grant_onehot: got %b want at most one bit", grant);
    end
    if (rst) begin
      vectors++;
      if ({out_valid, out_src, out_data} !== '0) begin
        miscompares++;
        $display("FAIL reset_out: got v=%b s=%0d d=%h want all zero", out_valid, out_src, out_data);
      end
      sb.delete();
      mptr = 0;
    end else begin
      vectors++;
      if (out_valid !== (sb.size() != 0)) begin
        miscompares++;
        $display("FAIL out_valid: got %b want %b", out_valid, (sb.size() != 0));
      end
      if (sb.size() != 0) begin
        vectors++;
        if ({out_src, out_data} !== sb[0]) begin
          miscompares++;
          $display("FAIL out_word: got src=%0d data=%h want src=%0d data=%h",
                   out_src, out_data, sb[0][SW+DW-1:DW], sb[0][DW-1:0]);
        end
        if (out_ready) void'(sb.pop_front());
      end
      if (found) begin
        sb.push_back({gi, req_data[gi*DW +: DW]});
        mptr = (gi == SW'(NR-1)) ? 0 : 32'(gi) + 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_grant(input string name, input logic [NR-1:0] want);
    vectors++;
    if (last_grant !== want) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", name, last_grant, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; out_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1; req_data = words(8'hA0);
    step();
    check_grant("reset_grant0", 4'b0000);
    step();
    check_grant("reset_grant1", 4'b0000);
    vectors++;
    if (samp_valid !== 1'b0 || samp_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_hold: got v=%b d=%h want v=0 d=00", samp_valid, samp_data);
    end
    rst = 1'b0;
    step();
    check_grant("reset_first_grant", 4'b0001);
  endtask

  task automatic test_rotation();
    logic [SW-1:0] seq[5];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111; out_ready = 1'b1; req_data = words(8'hA0);
    for (int unsigned k = 0; k < 6; k++) begin
      if (k == 5) req = '0;
      step();
      if (k < 5) check_grant("rot_grant", 4'b0001 << seq[k]);
      if (k > 0) begin
        vectors++;
        if (samp_valid !== 1'b1 || samp_src !== seq[k-1] || samp_data !== 8'hA0 + DW'(seq[k-1])) begin
          miscompares++;
          $display("FAIL rot_out: got v=%b src=%0d data=%h want v=1 src=%0d data=%h",
                   samp_valid, samp_src, samp_data, seq[k-1], 8'hA0 + DW'(seq[k-1]));
        end
      end
    end
  endtask

  task automatic test_skip_wrap();
    do_reset();
    out_ready = 1'b1; req_data = words(8'hC0);
    req = 4'b0100;
    step();
    check_grant("skip_setup", 4'b0100);
    req = 4'b0101;
    step();
    check_grant("skip_wrap0", 4'b0001);
    step();
    check_grant("skip_wrap2", 4'b0100);
    req = '0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; req_data = words(8'hB0);
    req = 4'b0001;
    step();
    check_grant("bp_fill", 4'b0001);
    req = 4'b0010;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      check_grant("bp_stall", 4'b0000);
      vectors++;
      if (samp_valid !== 1'b1 || samp_data !== 8'hB0) begin
        miscompares++;
        $display("FAIL bp_hold: got v=%b d=%h want v=1 d=b0", samp_valid, samp_data);
      end
    end
    out_ready = 1'b1;
    step();
    check_grant("bp_release", 4'b0010);
    req = '0;
    step();
    vectors++;
    if (samp_src !== 2'd1 || samp_data !== 8'hB1) begin
      miscompares++;
      $display("FAIL bp_next: got src=%0d d=%h want src=1 d=b1", samp_src, samp_data);
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; req_data = words(8'hD0);
    req = 4'b0001;
    step();
    req = 4'b1000;
    step();
    rst = 1'b1;
    step();
    vectors++;
    if (samp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_valid: got %b want 0", samp_valid);
    end
    rst = 1'b0; out_ready = 1'b1; req = 4'b0110;
    step();
    check_grant("mid_reset_first", 4'b0010);
    req = '0;
    step();
    step();
  endtask

  task automatic test_fairness();
    do_reset();
    req = 4'b0001;
    for (int unsigned i = 0; i < NR; i++) waitc[i] = 0;
    for (int unsigned c = 0; c < 2000; c++) begin
      req       = (req & ~last_grant) | NR'($urandom_range(0, 15)) | 4'b0001;
      out_ready = ($urandom_range(0, 3) != 0);
      req_data  = NR*DW'($urandom);
      step();
      for (int unsigned i = 0; i < NR; i++) begin
        if (last_grant[i]) waitc[i] = 0;
        else if (last_grant != '0 && req[i]) waitc[i]++;
        vectors++;
        if (waitc[i] > NR - 1) begin
          miscompares++;
          $display("FAIL fairness: requester %0d waited %0d transfers, limit %0d", i, waitc[i], NR - 1);
        end
      end
    end
    req = '0; out_ready = 1'b1;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1; req = '0; out_ready = 1'b0; req_data = '0;
    mptr = 0; last_grant = '0;
    test_reset();
    test_rotation();
    test_skip_wrap();
    test_backpressure();
    test_reset_mid();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
